// File: rtl/riscv_ram_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ram_lsu_if
// Description : Bus bundle between the RV core (IF + MEM stages) and the
//               unified instruction/data RAM.
//               Fetch channel : if_req/if_addr -> if_valid/if_inst/if_fault
//               Data request  : d_req/d_ready handshake carrying d_we, d_size,
//                               d_unsigned, d_addr, d_wdata
//               Data response : d_rvalid/d_rready handshake carrying d_rdata,
//                               d_fault
//               master = core side, slave = RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_ram_lsu_if #(
    parameter int WORD_LENGTH = 32
);
    // Fetch channel
    logic                   if_req;
    logic [WORD_LENGTH-1:0] if_addr;
    logic                   if_valid;
    logic [31:0]            if_inst;
    logic                   if_fault;

    // Data request channel
    logic                   d_req;
    logic                   d_ready;
    logic                   d_we;
    logic [1:0]             d_size;
    logic                   d_unsigned;
    logic [WORD_LENGTH-1:0] d_addr;
    logic [WORD_LENGTH-1:0] d_wdata;

    // Data response channel
    logic                   d_rvalid;
    logic                   d_rready;
    logic [WORD_LENGTH-1:0] d_rdata;
    logic                   d_fault;

    modport master (
        output if_req, if_addr,
        input  if_valid, if_inst, if_fault,
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  d_ready,
        output d_rready,
        input  d_rvalid, d_rdata, d_fault
    );

    modport slave (
        input  if_req, if_addr,
        output if_valid, if_inst, if_fault,
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output d_ready,
        input  d_rready,
        output d_rvalid, d_rdata, d_fault
    );
endinterface
`default_nettype wire

// File: rtl/riscv_ram_lsu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ram_lsu
// Description : Byte-addressed unified instruction/data RAM.
//               - Fetch port: registered 32-bit read, latency 1, no
//                 backpressure, faults on misalignment / out of range.
//               - Load/store port: valid/ready request, valid/ready response,
//                 byte/half/word(/double) accesses, sign/zero extension,
//                 byte-lane writes, misalignment / range / size faults.
// Ports       : clk  - clock, all state on rising edge
//               rst  - asynchronous active-high reset
//               bus  - riscv_ram_lsu_if.slave (fetch + data channels)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_ram_lsu #(
    parameter int    WORD_LENGTH = 32,
    parameter int    NUM_MEM     = 16384,
    parameter string INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            rst,
    riscv_ram_lsu_if.slave  bus
);

    localparam int c_ADDR_W = $clog2(NUM_MEM);
    localparam int c_NBYTES = WORD_LENGTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage. Never reset: contents survive rst and only change on stores.
    // ------------------------------------------------------------------------
    logic [7:0] r_mem [0:NUM_MEM-1];

    // ------------------------------------------------------------------------
    // Fetch port
    // ------------------------------------------------------------------------
    logic [c_ADDR_W-1:0] w_if_idx [0:3];
    logic [WORD_LENGTH:0] w_if_last;
    logic                w_if_fault;
    logic [31:0]         w_if_word;

    logic                r_if_valid;
    logic [31:0]         r_if_inst;
    logic                r_if_fault;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_if_idx[k] = bus.if_addr[c_ADDR_W-1:0] + c_ADDR_W'(k);
        end
        // One extra bit so an address near the top of the space cannot wrap
        // below NUM_MEM and slip past the range check.
        w_if_last  = {1'b0, bus.if_addr} + (WORD_LENGTH+1)'(3);
        w_if_fault = (bus.if_addr[1:0] != 2'b00) ||
                     (w_if_last >= (WORD_LENGTH+1)'(NUM_MEM));
        w_if_word  = {r_mem[w_if_idx[3]], r_mem[w_if_idx[2]],
                      r_mem[w_if_idx[1]], r_mem[w_if_idx[0]]};
    end

    // The memory write is a non-blocking update in the same edge, so a fetch
    // colliding with a store sees the pre-store bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'h0;
            r_if_fault <= 1'b0;
        end else begin
            r_if_valid <= bus.if_req;
            if (bus.if_req) begin
                r_if_fault <= w_if_fault;
                r_if_inst  <= w_if_fault ? 32'h0 : w_if_word;
            end
        end
    end

    assign bus.if_valid = r_if_valid;
    assign bus.if_inst  = r_if_inst;
    assign bus.if_fault = r_if_fault;

    // ------------------------------------------------------------------------
    // Data request decode
    // ------------------------------------------------------------------------
    logic [3:0]             w_nbytes;
    logic                   w_misaligned;
    logic                   w_out_of_range;
    logic                   w_bad_size;
    logic                   w_fault;
    logic [WORD_LENGTH:0]   w_last_byte;
    logic [c_ADDR_W-1:0]    w_byte_idx [0:c_NBYTES-1];
    logic [WORD_LENGTH-1:0] w_raw;
    logic [WORD_LENGTH-1:0] w_ext;
    logic                   w_sign;

    always_comb begin
        w_nbytes = 4'd1 << bus.d_size;

        case (bus.d_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = bus.d_addr[0];
            2'b10:   w_misaligned = (bus.d_addr[1:0] != 2'b00);
            default: w_misaligned = (bus.d_addr[2:0] != 3'b000);
        endcase

        w_last_byte    = {1'b0, bus.d_addr} + (WORD_LENGTH+1)'(w_nbytes - 4'd1);
        w_out_of_range = (w_last_byte >= (WORD_LENGTH+1)'(NUM_MEM));
        w_bad_size     = (bus.d_size == 2'b11) && (WORD_LENGTH == 32);
        w_fault        = w_misaligned || w_out_of_range || w_bad_size;
    end

    // Byte lane i always maps to address d_addr+i; lanes beyond the access
    // size are masked (reads) or left untouched (writes).
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < c_NBYTES; i++) begin
            w_byte_idx[i] = bus.d_addr[c_ADDR_W-1:0] + c_ADDR_W'(i);
            if (4'(i) < w_nbytes) begin
                w_raw[8*i +: 8] = r_mem[w_byte_idx[i]];
            end
        end
    end

    always_comb begin
        case (bus.d_size)
            2'b00:   w_sign = w_raw[7];
            2'b01:   w_sign = w_raw[15];
            2'b10:   w_sign = w_raw[31];
            default: w_sign = w_raw[WORD_LENGTH-1];
        endcase
        w_sign = w_sign & ~bus.d_unsigned;

        w_ext = '0;
        for (int j = 0; j < WORD_LENGTH; j++) begin
            w_ext[j] = (j < int'(w_nbytes) * 8) ? w_raw[j] : w_sign;
        end
    end

    // ------------------------------------------------------------------------
    // Data handshake FSM
    // ------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   r_ready_en;
    logic   w_ready;
    logic   w_accept;
    logic   w_store_en;

    // Keeps d_ready low from reset assertion until the first edge after
    // release, independent of d_rready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        // A held response is freed by d_rready in the same cycle, so a new
        // request can be taken back to back.
        w_ready      = r_ready_en && ((r_state == ST_IDLE) || bus.d_rready);
        w_accept     = bus.d_req && w_ready;
        w_store_en   = w_accept && bus.d_we && !w_fault;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.d_rready && !w_accept) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.d_ready  = w_ready;
    assign bus.d_rvalid = (r_state == ST_RESP);

    // ------------------------------------------------------------------------
    // Response registers: loaded on accept, held while the consumer stalls.
    // ------------------------------------------------------------------------
    logic [WORD_LENGTH-1:0] r_rdata;
    logic                   r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= (w_fault || bus.d_we) ? '0 : w_ext;
            r_fault <= w_fault;
        end else if ((r_state == ST_RESP) && bus.d_rready) begin
            r_rdata <= '0;
            r_fault <= 1'b0;
        end
    end

    assign bus.d_rdata = r_rdata;
    assign bus.d_fault = r_fault;

    // ------------------------------------------------------------------------
    // Byte-lane store
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_store_en) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (4'(i) < w_nbytes) begin
                    r_mem[w_byte_idx[i]] <= bus.d_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_ram_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_ram_lsu
// Description : Directed self-checking bench for riscv_ram_lsu. Data
//               responses are predicted when a request is driven and compared
//               when the response handshake completes; fetch results and
//               handshake timing are checked in line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_ram_lsu;

    localparam int WL = 32;
    localparam int NM = 16384;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    riscv_ram_lsu_if #(.WORD_LENGTH(WL)) bus ();

    riscv_ram_lsu #(
        .WORD_LENGTH (WL),
        .NUM_MEM     (NM),
        .INIT_FILE   ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [WL-1:0] rdata;
        logic          fault;
    } resp_t;

    resp_t sb[$];
    resp_t r_exp;
    int    n_tests  = 0;
    int    n_fail   = 0;
    int    n_pushed = 0;
    int    n_popped = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Drive one request for a single cycle; the DUT must be ready for it.
    task automatic req(input logic we, input logic [1:0] size, input logic uns,
                       input logic [WL-1:0] addr, input logic [WL-1:0] wdata,
                       input logic [WL-1:0] exp_rdata, input logic exp_fault,
                       input string tag);
        bus.d_req      = 1'b1;
        bus.d_we       = we;
        bus.d_size     = size;
        bus.d_unsigned = uns;
        bus.d_addr     = addr;
        bus.d_wdata    = wdata;
        #1;
        chk({tag, "_ready"}, 64'(bus.d_ready), 64'(1));
        sb.push_back('{rdata: exp_rdata, fault: exp_fault});
        n_pushed++;
        @(posedge clk);
        #2;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    // Response scoreboard: a response is consumed on the edge after a
    // negedge where d_rvalid && d_rready.
    always @(negedge clk) begin
        if (!rst && bus.d_rvalid && bus.d_rready) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(sb.size()), 64'(1));
            end else begin
                r_exp = sb.pop_front();
                n_popped++;
                chk($sformatf("resp%0d_rdata", n_popped), 64'(bus.d_rdata), 64'(r_exp.rdata));
                chk($sformatf("resp%0d_fault", n_popped), 64'(bus.d_fault), 64'(r_exp.fault));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_size     = 2'b00;
        bus.d_unsigned = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_rready   = 1'b1;

        // ---------------- reset state ----------------
        tick;
        tick;
        chk("rst_d_ready",  64'(bus.d_ready),  64'(0));
        chk("rst_d_rvalid", 64'(bus.d_rvalid), 64'(0));
        chk("rst_d_rdata",  64'(bus.d_rdata),  64'(0));
        chk("rst_d_fault",  64'(bus.d_fault),  64'(0));
        chk("rst_if_valid", 64'(bus.if_valid), 64'(0));
        chk("rst_if_inst",  64'(bus.if_inst),  64'(0));
        chk("rst_if_fault", 64'(bus.if_fault), 64'(0));
        rst = 1'b0;
        #1;
        chk("rel_ready_before_edge", 64'(bus.d_ready), 64'(0));
        @(posedge clk);
        #2;
        chk("rel_ready_after_edge", 64'(bus.d_ready), 64'(1));

        // ---------------- store word, load back ----------------
        req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, "st_w");
        chk("st_ack_valid", 64'(bus.d_rvalid), 64'(1));
        req(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w");
        chk("ld_w_valid_lat1", 64'(bus.d_rvalid), 64'(1));
        chk("ld_w_data_lat1",  64'(bus.d_rdata),  64'(32'hDEADBEEF));

        // ---------------- byte lanes and extension ----------------
        req(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0, 1'b0, "st_w2");
        req(1'b1, 2'b00, 1'b0, 32'h101, 32'hAAAAAA80, 32'h0, 1'b0, "st_b");
        req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFF80, 1'b0, "ld_bs");
        req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h00000080, 1'b0, "ld_bu");
        req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11228044, 1'b0, "ld_w3");
        req(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'hFFFF8044, 1'b0, "ld_hs");
        req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h00001122, 1'b0, "ld_hu");

        // ---------------- faults ----------------
        req(1'b0, 2'b01, 1'b0, 32'h103,       32'h0, 32'h0, 1'b1, "ld_h_mis");
        req(1'b0, 2'b10, 1'b0, 32'h102,       32'h0, 32'h0, 1'b1, "ld_w_mis");
        req(1'b1, 2'b10, 1'b0, 32'h102,       32'h55667788, 32'h0, 1'b1, "st_w_mis");
        req(1'b1, 2'b00, 1'b0, 32'h4100,      32'h000000EE, 32'h0, 1'b1, "st_b_oor");
        req(1'b0, 2'b10, 1'b0, 32'h100,       32'h0, 32'h11228044, 1'b0, "ld_unchanged");
        req(1'b0, 2'b01, 1'b0, 32'h4000,      32'h0, 32'h0, 1'b1, "ld_h_oor");
        req(1'b0, 2'b10, 1'b0, 32'h10100,     32'h0, 32'h0, 1'b1, "ld_w_highbits");
        req(1'b0, 2'b11, 1'b0, 32'h100,       32'h0, 32'h0, 1'b1, "ld_d_size");
        req(1'b1, 2'b10, 1'b0, 32'(NM - 4),   32'hCAFEF00D, 32'h0, 1'b0, "st_w_top");
        req(1'b0, 2'b10, 1'b0, 32'(NM - 4),   32'h0, 32'hCAFEF00D, 1'b0, "ld_w_top");
        req(1'b0, 2'b00, 1'b1, 32'(NM - 1),   32'h0, 32'h000000CA, 1'b0, "ld_b_top");
        req(1'b0, 2'b01, 1'b0, 32'(NM - 1),   32'h0, 32'h0, 1'b1, "ld_h_top_mis");
        req(1'b0, 2'b00, 1'b0, 32'h100,       32'h0, 32'h00000044, 1'b0, "ld_b_after_oor");

        // ---------------- fetch port ----------------
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h102;
        tick;
        chk("if_mis_valid", 64'(bus.if_valid), 64'(1));
        chk("if_mis_fault", 64'(bus.if_fault), 64'(1));
        chk("if_mis_inst",  64'(bus.if_inst),  64'(0));
        bus.if_addr = 32'h100;
        tick;
        chk("if_ok_fault", 64'(bus.if_fault), 64'(0));
        chk("if_ok_inst",  64'(bus.if_inst),  64'(32'h11228044));
        bus.if_addr = 32'(NM);
        tick;
        chk("if_oor_fault", 64'(bus.if_fault), 64'(1));
        chk("if_oor_inst",  64'(bus.if_inst),  64'(0));
        bus.if_req = 1'b0;
        tick;
        chk("if_idle_valid", 64'(bus.if_valid), 64'(0));

        // ---------------- backpressure ----------------
        req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11228044, 1'b0, "ld_hold");
        bus.d_rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_ready", k),  64'(bus.d_ready),  64'(0));
            chk($sformatf("hold%0d_rvalid", k), 64'(bus.d_rvalid), 64'(1));
            chk($sformatf("hold%0d_rdata", k),  64'(bus.d_rdata),  64'(32'h11228044));
            @(posedge clk);
            #1;
        end
        #1;
        bus.d_rready = 1'b1;
        req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h00000080, 1'b0, "ld_b2b");
        tick;
        chk("b2b_no_loss", 64'(n_popped), 64'(n_pushed));

        // ---------------- fetch/store collision ----------------
        req(1'b1, 2'b10, 1'b0, 32'h200, 32'hFFFFFFFF, 32'h0, 1'b0, "st_ff");
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        req(1'b1, 2'b10, 1'b0, 32'h200, 32'h00000013, 32'h0, 1'b0, "st_coll");
        chk("coll_if_valid", 64'(bus.if_valid), 64'(1));
        chk("coll_if_old",   64'(bus.if_inst),  64'(32'hFFFFFFFF));
        tick;
        chk("coll_if_new",   64'(bus.if_inst),  64'(32'h00000013));
        bus.if_req = 1'b0;

        // ---------------- reset while a response is held ----------------
        req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h00000013, 1'b0, "ld_pre_rst");
        bus.d_rready = 1'b0;
        #1;
        chk("pre_rst_rvalid", 64'(bus.d_rvalid), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_async_rvalid", 64'(bus.d_rvalid), 64'(0));
        chk("rst_async_ready",  64'(bus.d_ready),  64'(0));
        chk("rst_async_rdata",  64'(bus.d_rdata),  64'(0));
        n_pushed = n_pushed - sb.size();
        sb.delete();
        tick;
        rst          = 1'b0;
        bus.d_rready = 1'b1;
        tick;
        chk("post_rst_ready", 64'(bus.d_ready), 64'(1));
        req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h00000013, 1'b0, "ld_post_rst1");
        req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11228044, 1'b0, "ld_post_rst2");
        tick;
        tick;
        chk("sb_drained",  64'(sb.size()), 64'(0));
        chk("resp_count",  64'(n_popped),  64'(n_pushed));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
